// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multi-port register file
package regfile_pkg;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic {
        RF_SCRUB,
        RF_RUN
    } rf_state_e;

    localparam int RV32I_NREG = 32;
    localparam int RV32E_NREG = 16;

    function automatic logic addr_in_range(input reg_addr_t addr, input int nreg);
        return int'(addr) < nreg;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with set-over-clear priority
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int NRP  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr_en,
    input  reg_addr_t        clr_addr,
    input  logic             set_en,
    input  reg_addr_t        set_addr,
    input  logic [NRP*5-1:0] rd_addr,
    output logic [NRP-1:0]   rd_pend
);

    logic [NREG-1:0] pend_q, pend_d;
    logic [NRP-1:0]  rd_pend_q, rd_pend_d;

    always_comb begin
        pend_d = pend_q;
        // Set is applied after clear so an issue to the register being retired wins.
        for (int i = 1; i < NREG; i++) begin
            if (clr_en && clr_addr == 5'(i)) pend_d[i] = 1'b0;
            if (set_en && set_addr == 5'(i)) pend_d[i] = 1'b1;
        end
        pend_d[0] = 1'b0;

        rd_pend_d = '0;
        for (int p = 0; p < NRP; p++) begin
            for (int i = 1; i < NREG; i++) begin
                if (run && rd_addr[p*5 +: 5] == 5'(i)) rd_pend_d[p] = pend_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q    <= '0;
            rd_pend_q <= '0;
        end else begin
            pend_q    <= pend_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign rd_pend = rd_pend_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with bypass, scrub and scoreboard
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int DW     = 32,
    parameter int NREG   = 32,
    parameter int NRP    = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_busy,
    input  logic              wr_en_wb,
    input  logic [4:0]        wr_addr_wb,
    input  logic [DW-1:0]     wr_data_wb,
    input  logic              sb_set_en,
    input  logic [4:0]        sb_set_addr,
    input  logic [NRP*5-1:0]  rd_addr_r,
    output logic [NRP*DW-1:0] rd_data_e,
    output logic [NRP-1:0]    rd_pend_e,
    output logic              addr_err
);

    rf_state_e          state_q, state_d;
    reg_addr_t          cnt_q, cnt_d;
    logic               init_busy_q, init_busy_d;
    logic               addr_err_q, addr_err_d;
    logic [NRP*DW-1:0]  rd_data_q, rd_data_d;
    logic [DW-1:0]      mem_q [1:NREG-1];
    logic [DW-1:0]      mem_d [1:NREG-1];

    logic run, wr_ok, set_ok, any_bad;

    assign run    = (state_q == RF_RUN);
    assign wr_ok  = run && wr_en_wb && wr_addr_wb != 5'd0 && addr_in_range(wr_addr_wb, NREG);
    assign set_ok = run && sb_set_en && sb_set_addr != 5'd0 && addr_in_range(sb_set_addr, NREG);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_busy_d = init_busy_q;
        if (state_q == RF_SCRUB) begin
            if (cnt_q == 5'(NREG - 1)) begin
                state_d     = RF_RUN;
                init_busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_comb begin
        for (int i = 1; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
            if (!run && cnt_q == 5'(i))
                mem_d[i] = '0;
            else if (wr_ok && wr_addr_wb == 5'(i))
                mem_d[i] = wr_data_wb;
        end
    end

    // x0 and out-of-range addresses never match a loop index, so they read as zero.
    always_comb begin
        rd_data_d = '0;
        for (int p = 0; p < NRP; p++) begin
            for (int i = 1; i < NREG; i++) begin
                if (run && rd_addr_r[p*5 +: 5] == 5'(i)) begin
                    if (BYPASS != 0 && wr_en_wb && wr_addr_wb == 5'(i))
                        rd_data_d[p*DW +: DW] = wr_data_wb;
                    else
                        rd_data_d[p*DW +: DW] = mem_q[i];
                end
            end
        end
    end

    always_comb begin
        any_bad = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            if (!addr_in_range(rd_addr_r[p*5 +: 5], NREG)) any_bad = 1'b1;
        end
        if (wr_en_wb && !addr_in_range(wr_addr_wb, NREG)) any_bad = 1'b1;
        if (sb_set_en && !addr_in_range(sb_set_addr, NREG)) any_bad = 1'b1;
        addr_err_d = run && any_bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RF_SCRUB;
            cnt_q       <= 5'd1;
            init_busy_q <= 1'b1;
            addr_err_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_busy_q <= init_busy_d;
            addr_err_q  <= addr_err_d;
            rd_data_q   <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    rf_scoreboard #(
        .NREG (NREG),
        .NRP  (NRP)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .clr_en   (wr_ok),
        .clr_addr (wr_addr_wb),
        .set_en   (set_ok),
        .set_addr (sb_set_addr),
        .rd_addr  (rd_addr_r),
        .rd_pend  (rd_pend_e)
    );

    assign init_busy = init_busy_q;
    assign addr_err  = addr_err_q;
    assign rd_data_e = rd_data_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - checks three register file configurations against a behavioural model
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        set_en;
    logic [4:0]  set_addr;
    logic [9:0]  rd_addr;

    logic        busy_a, busy_b, busy_e;
    logic        err_a, err_b, err_e;
    logic [63:0] data_a, data_b, data_e;
    logic [1:0]  pend_a, pend_b, pend_e;

    logic [2:0]  act_busy, act_err;
    logic [63:0] act_data [3];
    logic [1:0]  act_pend [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DW(32), .NREG(32), .NRP(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .init_busy(busy_a),
        .wr_en_wb(wr_en), .wr_addr_wb(wr_addr), .wr_data_wb(wr_data),
        .sb_set_en(set_en), .sb_set_addr(set_addr), .rd_addr_r(rd_addr),
        .rd_data_e(data_a), .rd_pend_e(pend_a), .addr_err(err_a));

    reg_file_mp #(.DW(32), .NREG(32), .NRP(2), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .init_busy(busy_b),
        .wr_en_wb(wr_en), .wr_addr_wb(wr_addr), .wr_data_wb(wr_data),
        .sb_set_en(set_en), .sb_set_addr(set_addr), .rd_addr_r(rd_addr),
        .rd_data_e(data_b), .rd_pend_e(pend_b), .addr_err(err_b));

    reg_file_mp #(.DW(32), .NREG(16), .NRP(2), .BYPASS(1)) dut_e (
        .clk(clk), .rst(rst), .init_busy(busy_e),
        .wr_en_wb(wr_en), .wr_addr_wb(wr_addr), .wr_data_wb(wr_data),
        .sb_set_en(set_en), .sb_set_addr(set_addr), .rd_addr_r(rd_addr),
        .rd_data_e(data_e), .rd_pend_e(pend_e), .addr_err(err_e));

    assign act_busy    = {busy_e, busy_b, busy_a};
    assign act_err     = {err_e, err_b, err_a};
    assign act_data[0] = data_a;
    assign act_data[1] = data_b;
    assign act_data[2] = data_e;
    assign act_pend[0] = pend_a;
    assign act_pend[1] = pend_b;
    assign act_pend[2] = pend_e;

    int          nreg_of [3] = '{32, 32, 16};
    bit          byp_of  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_mem   [3][32];
    bit          m_pend  [3][32];
    int          m_edges [3];
    logic [31:0] e_data  [3][2];
    bit          e_pend  [3][2];
    bit          e_busy  [3];
    bit          e_err   [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input int k);
        int n;
        bit wv, sv;
        logic [4:0] a;
        n = nreg_of[k];
        if (m_edges[k] < n - 1) begin
            m_edges[k]++;
            e_busy[k] = (m_edges[k] < n - 1);
            e_err[k]  = 1'b0;
            for (int p = 0; p < 2; p++) begin
                e_data[k][p] = '0;
                e_pend[k][p] = 1'b0;
            end
            return;
        end
        e_busy[k] = 1'b0;
        wv = wr_en && wr_addr != 0 && int'(wr_addr) < n;
        sv = set_en && set_addr != 0 && int'(set_addr) < n;
        if (wv) m_pend[k][wr_addr] = 1'b0;
        if (sv) m_pend[k][set_addr] = 1'b1;
        e_err[k] = 1'b0;
        for (int p = 0; p < 2; p++) begin
            a = rd_addr[p*5 +: 5];
            if (a == 0 || int'(a) >= n) begin
                e_data[k][p] = '0;
                e_pend[k][p] = 1'b0;
                if (int'(a) >= n) e_err[k] = 1'b1;
            end else begin
                e_data[k][p] = (byp_of[k] && wr_en && wr_addr == a) ? wr_data : m_mem[k][a];
                e_pend[k][p] = m_pend[k][a];
            end
        end
        if (wr_en && int'(wr_addr) >= n) e_err[k] = 1'b1;
        if (set_en && int'(set_addr) >= n) e_err[k] = 1'b1;
        if (wv) m_mem[k][wr_addr] = wr_data;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_edges[k] = 0;
                e_busy[k]  = 1'b1;
                e_err[k]   = 1'b0;
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i]  = '0;
                    m_pend[k][i] = 1'b0;
                end
                for (int p = 0; p < 2; p++) begin
                    e_data[k][p] = '0;
                    e_pend[k][p] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) model_step(k);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("init_busy k%0d", k), 32'(act_busy[k]), 32'(e_busy[k]));
                check($sformatf("addr_err k%0d", k), 32'(act_err[k]), 32'(e_err[k]));
                for (int p = 0; p < 2; p++) begin
                    check($sformatf("rd_data k%0d p%0d", k, p), act_data[k][p*32 +: 32], e_data[k][p]);
                    check($sformatf("rd_pend k%0d p%0d", k, p), 32'(act_pend[k][p]), 32'(e_pend[k][p]));
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic se, input logic [4:0] sa,
                         input logic [4:0] r0, input logic [4:0] r1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        set_en   = se;
        set_addr = sa;
        rd_addr  = {r1, r0};
        @(negedge clk);
    endtask

    initial begin
        int fa, fe;
        rst = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        set_en = 1'b0; set_addr = '0; rd_addr = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(act_busy), 32'h7);
        check("reset err", 32'(act_err), 32'h0);
        check("reset data_a", data_a[31:0], 32'h0);
        check("reset pend_e", 32'(pend_e), 32'h0);

        #2 rst = 1'b0;
        fa = 0;
        fe = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (fa == 0 && !busy_a) fa = c;
            if (fe == 0 && !busy_e) fe = c;
        end
        check("scrub edges rv32i", 32'(fa), 32'd31);
        check("scrub edges rv32e", 32'(fe), 32'd15);
        @(negedge clk);

        for (int a = 0; a < 32; a++) drive(0, 0, 0, 0, 0, 5'(a), 5'(31 - a));

        drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
        check("bypass on x5", data_a[31:0], 32'hDEADBEEF);
        check("bypass off x5 old", data_b[31:0], 32'h0);
        drive(0, 0, 0, 0, 0, 5, 0);
        check("bypass off x5 new", data_b[31:0], 32'hDEADBEEF);

        drive(1, 0, 32'h1234, 1, 0, 0, 0);
        check("x0 data", data_a[31:0], 32'h0);
        check("x0 pend", 32'(pend_a[0]), 32'h0);

        drive(0, 0, 0, 1, 7, 7, 0);
        check("x7 set", 32'(pend_a[0]), 32'h1);
        drive(0, 0, 0, 0, 0, 7, 0);
        drive(0, 0, 0, 0, 0, 7, 0);
        drive(1, 7, 32'h77, 1, 7, 7, 0);
        check("x7 set wins a", 32'(pend_a[0]), 32'h1);
        check("x7 set wins e", 32'(pend_e[0]), 32'h1);
        drive(1, 7, 32'h78, 0, 0, 7, 0);
        check("x7 cleared", 32'(pend_a[0]), 32'h0);

        drive(1, 4, 32'h44, 0, 0, 0, 0);
        drive(1, 20, 32'hFF, 0, 0, 20, 4);
        check("rv32e addr_err pulse", 32'(err_e), 32'h1);
        check("rv32i no addr_err", 32'(err_a), 32'h0);
        check("rv32e x20 reads 0", data_e[31:0], 32'h0);
        check("rv32e x4 kept", data_e[63:32], 32'h44);
        check("rv32i x20 bypass", data_a[31:0], 32'hFF);
        drive(0, 0, 0, 0, 0, 5, 4);
        check("rv32e addr_err ends", 32'(err_e), 32'h0);
        check("rv32e x4 still", data_e[63:32], 32'h44);

        drive(1, 3, 32'h55, 0, 0, 3, 0);
        drive(0, 0, 0, 1, 3, 3, 0);
        check("x3 pend before rst", 32'(pend_a[0]), 32'h1);
        check("x3 data before rst", data_a[31:0], 32'h55);
        #2 rst = 1'b1;
        #1;
        check("mid rst pend", 32'(pend_a), 32'h0);
        check("mid rst busy", 32'(act_busy), 32'h7);
        check("mid rst data", data_a[31:0], 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (act_busy == 3'b000) break;
        end
        check("scrub done after rst", 32'(act_busy), 32'h0);
        drive(0, 0, 0, 0, 0, 3, 3);
        check("x3 scrubbed a", data_a[31:0], 32'h0);
        check("x3 scrubbed e", data_e[31:0], 32'h0);
        check("x3 pend after rst", 32'(pend_a[0]), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the RV32 core: configurable data width, register count (32 for RV32I, 16 for RV32E) and read-port count. Adds to the basic register file:
- write-to-read bypass
- a post-reset scrub sequencer that clears storage one entry per cycle
- a per-register pending scoreboard for hazard detection

Sits between decode (read addresses, issue marking) and writeback (write port). Read data and pending flags feed the execute stage one cycle later.

## Interface
- DW, 32: data width in bits
- NREG, 32: architectural register count; legal values are 16 or 32
- NRP, 2: number of read ports; range 1..4
- BYPASS, 1: 1 = same-cycle writeback is forwarded to reads; 0 = reads return pre-write storage
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- init_busy  out  1  high while the scrub sequencer runs; upstream must not issue while high
- wr_en_wb  in  1  writeback enable
- wr_addr_wb  in  5  writeback register address
- wr_data_wb  in  DW  writeback data
- sb_set_en  in  1  issue strobe: marks sb_set_addr as pending
- sb_set_addr  in  5  destination register of the issued instruction
- rd_addr_r  in  NRP×5  packed read addresses, one per port
- rd_data_e  out  NRP×DW  registered read data, one per port
- rd_pend_e  out  NRP  registered pending flag, one per port
- addr_err  out  1  one-cycle pulse when any port presents an address ≥ NREG

## Operation
- Storage: entries 1..NREG-1 are flops without reset. x0 is not stored; it reads as 0 and is never pending.
- Scrub FSM:
  - States: RF_SCRUB, RF_RUN.
  - Reset enters RF_SCRUB with counter = 1.
  - Each clock in RF_SCRUB writes 0 to entry[counter] and increments the counter.
  - When counter = NREG-1 and that entry has been cleared, the FSM moves to RF_RUN.
  - RF_RUN is terminal until the next reset.
- During RF_SCRUB: wr_en_wb and sb_set_en are ignored, rd_data_e = 0, rd_pend_e = 0.
- Write: in RF_RUN, wr_en_wb with address ≠ 0 and < NREG updates the entry.
- Read, per port p:
  - rd_data_e[p] <= 0 if the address is 0 or ≥ NREG.
  - Otherwise, if BYPASS and wr_en_wb and wr_addr_wb = rd_addr_r[p], rd_data_e[p] <= wr_data_wb.
  - Otherwise rd_data_e[p] <= entry.
- Scoreboard: pend[i] is an async-reset flop, reset value 0.
  - Cleared by a valid write to i.
  - Set by sb_set_en to i (address ≠ 0, < NREG).
  - If set and clear hit the same i in the same cycle, set wins.
- rd_pend_e[p] <= pend_next[rd_addr_r[p]], i.e. the state after this cycle's set/clear. It is 0 for address 0 or an illegal address.
- Illegal addresses (≥ NREG, RV32E only):
  - Writes and sets are dropped.
  - Reads return 0.
  - addr_err <= 1 for one cycle if any read, write (with wr_en_wb) or set (with sb_set_en) address is ≥ NREG, in RF_RUN only.
- Reset mid-operation: the FSM returns to RF_SCRUB and all pend bits clear immediately. Storage is re-cleared by the scrub.

## Timing
- Reset values: rd_data_e = 0, rd_pend_e = 0, init_busy = 1, addr_err = 0, FSM = RF_SCRUB, counter = 1.
- Scrub length: init_busy stays high for exactly NREG-1 rising edges after rst deasserts (31 for RV32I, 15 for RV32E). It falls on the edge that clears entry NREG-1.
- Read latency: 1 cycle; the address is sampled at edge N and data is valid after edge N.
- Bypass: a write at edge N is visible on a read sampled at edge N if BYPASS = 1, otherwise at edge N+1.
- Scoreboard: a set at edge N is reflected on a read at edge N. A clear at edge N is reflected on a read at edge N.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package regfile_pkg contains:
  - typedef reg_addr_t (logic [4:0])
  - enum rf_state_e {RF_SCRUB, RF_RUN}
  - constants RV32I_NREG = 32 and RV32E_NREG = 16
- Sub-module rf_scoreboard holds the NREG pending bits, the set/clear priority logic and the NRP pending read muxes.
- reg_file_mp contains storage, bypass muxes, the scrub FSM and addr_err generation.

## Test plan
- Reset release, NREG=32 → init_busy high for 31 edges, then low; all 31 entries then read 0.
- Write x5=0xDEADBEEF while port 0 reads x5 in the same cycle, BYPASS=1 → rd_data_e[0]=0xDEADBEEF next cycle. With BYPASS=0 → old value 0, then 0xDEADBEEF one cycle later.
- Write x0=0x1234 and sb_set x0 → reads of x0 return 0 and rd_pend_e=0.
- sb_set x7, then 3 cycles later a write to x7 with sb_set x7 in the same cycle → rd_pend_e stays 1. A later write to x7 alone → 0.
- NREG=16: read x20, write x20=0xFF → addr_err pulses for one cycle, read returns 0, and x4 is unchanged.
- Assert rst mid-run with x3 pending and holding 0x55 → pend clears at once, init_busy=1, and x3 reads 0 after the scrub.
